// File: rtl/sprite_mover.sv
// sprite_mover: steps one rectangular sprite across the playfield, erasing and
// redrawing it pixel by pixel. Define SPRITE_MOVER_WRAP_EN to wrap at the borders instead of clamping.
module sprite_mover #(
  parameter int unsigned SPRITE_W        = 4,
  parameter int unsigned SPRITE_H        = 4,
  parameter int unsigned X_START         = 10,
  parameter int unsigned Y_START         = 58,
  parameter logic [2:0]  COLOUR          = 3'd2,
  parameter int unsigned CLKS_PER_FRAME  = 833334,
  parameter int unsigned FRAMES_PER_STEP = 15,
  parameter int unsigned STEP            = 1,
  parameter int unsigned SCREEN_W        = 160,
  parameter int unsigned SCREEN_H        = 120
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] dir,
  input  logic       ready,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic       edge_pulse  // boundary pulse; the word edge is reserved in SystemVerilog
);

  localparam int unsigned MAX_X = SCREEN_W - SPRITE_W;
  localparam int unsigned MAX_Y = SCREEN_H - SPRITE_H;
  localparam int unsigned COL_W = $clog2(SPRITE_W + 1);
  localparam int unsigned ROW_W = $clog2(SPRITE_H + 1);
  localparam int unsigned FRM_W = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
  localparam int unsigned STP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  // Landing position when a step goes past the max (OVER) or below zero (UNDER).
`ifdef SPRITE_MOVER_WRAP_EN
  localparam logic [7:0] X_OVER  = 8'd0;
  localparam logic [7:0] X_UNDER = 8'(MAX_X);
  localparam logic [6:0] Y_OVER  = 7'd0;
  localparam logic [6:0] Y_UNDER = 7'(MAX_Y);
`else
  localparam logic [7:0] X_OVER  = 8'(MAX_X);
  localparam logic [7:0] X_UNDER = 8'd0;
  localparam logic [6:0] Y_OVER  = 7'(MAX_Y);
  localparam logic [6:0] Y_UNDER = 7'd0;
`endif

  typedef enum logic [2:0] {S_INIT, S_WAIT, S_ERASE, S_UPDATE, S_DRAW} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pos_x_q, pos_x_d;
  logic [6:0]       pos_y_q, pos_y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [STP_W-1:0] steps_q, steps_d;
  logic             pending_q, pending_d;
  logic             plot_q, plot_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             edge_q, edge_d;

  logic       tick, step, last_px, hit;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic [7:0] next_x;
  logic [6:0] next_y;

  // Frame and step timers; frozen while enable is low.
  always_comb begin
    frame_d = frame_q;
    steps_d = steps_q;
    tick    = 1'b0;
    step    = 1'b0;
    if (enable) begin
      if (frame_q == '0) begin
        frame_d = FRM_W'(CLKS_PER_FRAME - 1);
        tick    = 1'b1;
      end else begin
        frame_d = frame_q - FRM_W'(1);
      end
    end
    if (tick) begin
      if (steps_q == '0) begin
        steps_d = STP_W'(FRAMES_PER_STEP - 1);
        step    = 1'b1;
      end else begin
        steps_d = steps_q - STP_W'(1);
      end
    end
  end

  // Candidate position after one step; one extra bit exposes underflow.
  always_comb begin
    sum_x  = {1'b0, pos_x_q};
    sum_y  = {1'b0, pos_y_q};
    next_x = pos_x_q;
    next_y = pos_y_q;
    hit    = 1'b0;
    case (dir)
      2'b00: begin
        sum_x = {1'b0, pos_x_q} + 9'(STEP);
        if (sum_x > 9'(MAX_X)) begin
          next_x = X_OVER;
          hit    = 1'b1;
        end else begin
          next_x = sum_x[7:0];
        end
      end
      2'b01: begin
        sum_x = {1'b0, pos_x_q} - 9'(STEP);
        if (sum_x[8]) begin
          next_x = X_UNDER;
          hit    = 1'b1;
        end else begin
          next_x = sum_x[7:0];
        end
      end
      2'b10: begin
        sum_y = {1'b0, pos_y_q} + 8'(STEP);
        if (sum_y > 8'(MAX_Y)) begin
          next_y = Y_OVER;
          hit    = 1'b1;
        end else begin
          next_y = sum_y[6:0];
        end
      end
      default: begin
        sum_y = {1'b0, pos_y_q} - 8'(STEP);
        if (sum_y[7]) begin
          next_y = Y_UNDER;
          hit    = 1'b1;
        end else begin
          next_y = sum_y[6:0];
        end
      end
    endcase
  end

  // Sequencer: pixel scan, position update and registered output values.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    edge_d  = 1'b0;
    last_px = (col_q == COL_W'(SPRITE_W - 1)) && (row_q == ROW_W'(SPRITE_H - 1));
    case (state_q)
      S_INIT:   state_d = S_DRAW;
      S_WAIT:   if (pending_q) state_d = S_ERASE;
      S_UPDATE: state_d = S_DRAW;
      S_ERASE, S_DRAW: begin
        if (plot_q && ready) begin
          if (last_px) begin
            col_d = '0;
            row_d = '0;
            if (state_q == S_ERASE) begin
              state_d = S_UPDATE;
              pos_x_d = next_x;
              pos_y_d = next_y;
              edge_d  = hit;
            end else begin
              state_d = S_WAIT;
              done_d  = 1'b1;
            end
          end else if (col_q == COL_W'(SPRITE_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default:  state_d = S_INIT;
    endcase
    // A new step request beats the clear on ERASE entry.
    if (step) begin
      pending_d = 1'b1;
    end else if (state_q == S_WAIT && pending_q) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    plot_d   = (state_d == S_ERASE) || (state_d == S_DRAW);
    busy_d   = (state_d == S_ERASE) || (state_d == S_UPDATE) || (state_d == S_DRAW);
    colour_d = (state_d == S_DRAW) ? COLOUR : 3'd0;
    x_d      = pos_x_d + 8'(col_d);
    y_d      = pos_y_d + 7'(row_d);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_INIT;
      pos_x_q   <= 8'(X_START);
      pos_y_q   <= 7'(Y_START);
      col_q     <= '0;
      row_q     <= '0;
      frame_q   <= FRM_W'(CLKS_PER_FRAME - 1);
      steps_q   <= STP_W'(FRAMES_PER_STEP - 1);
      pending_q <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= 8'(X_START);
      y_q       <= 7'(Y_START);
      colour_q  <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      col_q     <= col_d;
      row_q     <= row_d;
      frame_q   <= frame_d;
      steps_q   <= steps_d;
      pending_q <= pending_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      edge_q    <= edge_d;
    end
  end

  assign plot       = plot_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign edge_pulse = edge_q;

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed bench with a cycle-level reference model of the
// sprite engine; builds with or without SPRITE_MOVER_WRAP_EN.
module tb_sprite_mover;

  localparam int W = 4, H = 4, XS = 10, YS = 58, CPF = 4, FPS = 2, STP = 1;
  localparam int SW = 160, SH = 120;
  localparam logic [2:0] COL = 3'd2;
  localparam int MAXX = SW - W, MAXY = SH - H, NPIX = W * H, PERIOD = CPF * FPS;
`ifdef SPRITE_MOVER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int P_INIT = 0, P_WAIT = 1, P_ERASE = 2, P_UPD = 3, P_DRAW = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic       ready = 1'b1;
  logic [1:0] dir = 2'b00;
  logic       plot, busy, done, edge_pulse;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sprite_mover #(
    .SPRITE_W(W), .SPRITE_H(H), .X_START(XS), .Y_START(YS), .COLOUR(COL),
    .CLKS_PER_FRAME(CPF), .FRAMES_PER_STEP(FPS), .STEP(STP),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .dir(dir), .ready(ready),
    .plot(plot), .x(x), .y(y), .colour(colour), .busy(busy), .done(done),
    .edge_pulse(edge_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, pixel index and position; steps come from the
  // count of enabled cycles since reset.
  int m_ph, m_x, m_y, m_idx, m_en;
  int m_pend, m_done, m_edge;
  initial begin
    int st, go;
    forever begin
      @(posedge clock);
      if (!resetn) begin
        m_ph = P_INIT; m_x = XS; m_y = YS; m_idx = 0; m_en = 0;
        m_pend = 0; m_done = 0; m_edge = 0;
      end else begin
        st = (enable && (m_en % PERIOD == PERIOD - 1)) ? 1 : 0;
        if (enable) m_en++;
        m_done = 0; m_edge = 0; go = 0;
        case (m_ph)
          P_INIT: m_ph = P_DRAW;
          P_WAIT: if (m_pend != 0) begin m_ph = P_ERASE; go = 1; end
          P_UPD:  m_ph = P_DRAW;
          P_ERASE: if (ready) begin
            if (m_idx == NPIX - 1) begin
              m_idx = 0; m_ph = P_UPD;
              case (dir)
                2'b00: begin m_x += STP; if (m_x > MAXX) begin m_edge = 1; m_x = WRAP ? 0 : MAXX; end end
                2'b01: begin m_x -= STP; if (m_x < 0)    begin m_edge = 1; m_x = WRAP ? MAXX : 0; end end
                2'b10: begin m_y += STP; if (m_y > MAXY) begin m_edge = 1; m_y = WRAP ? 0 : MAXY; end end
                default: begin m_y -= STP; if (m_y < 0)  begin m_edge = 1; m_y = WRAP ? MAXY : 0; end end
              endcase
            end else m_idx++;
          end
          default: if (ready) begin
            if (m_idx == NPIX - 1) begin m_idx = 0; m_ph = P_WAIT; m_done = 1; end
            else m_idx++;
          end
        endcase
        if (st != 0) m_pend = 1;
        else if (go != 0) m_pend = 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("plot",   int'(plot),   (m_ph == P_ERASE || m_ph == P_DRAW) ? 1 : 0);
      check("x",      int'(x),      m_x + m_idx % W);
      check("y",      int'(y),      m_y + m_idx / W);
      check("colour", int'(colour), (m_ph == P_DRAW) ? int'(COL) : 0);
      check("busy",   int'(busy),   (m_ph == P_ERASE || m_ph == P_UPD || m_ph == P_DRAW) ? 1 : 0);
      check("done",   int'(done),   m_done);
      check("edge",   int'(edge_pulse), m_edge);
    end
  end

  task automatic wait_update(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (busy && !plot) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_until_edge(input int limit, output bit got, output int gx, output int gy);
    got = 1'b0; gx = -1; gy = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (edge_pulse) begin got = 1'b1; gx = int'(x); gy = int'(y); break; end
    end
  endtask

  initial begin
    bit got;
    int n, gx, gy;
    bit r;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x), 10);
    check("rst_y", int'(y), 58);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    resetn = 1'b1;                       // this cycle is INIT (c=0)

    @(negedge clock);                    // c=1 first draw pixel
    check("c1_plot", int'(plot), 1);
    check("c1_x", int'(x), 10);
    check("c1_colour", int'(colour), 2);
    repeat (15) @(negedge clock);        // c=16 last draw pixel
    check("c16_x", int'(x), 13);
    check("c16_y", int'(y), 61);
    @(negedge clock);                    // c=17 done
    check("c17_done", int'(done), 1);
    check("c17_busy", int'(busy), 0);
    @(negedge clock);                    // c=18 first erase pixel
    check("c18_plot", int'(plot), 1);
    check("c18_colour", int'(colour), 0);
    check("c18_x", int'(x), 10);
    repeat (16) @(negedge clock);        // c=34 update
    check("c34_busy", int'(busy), 1);
    check("c34_plot", int'(plot), 0);
    check("c34_edge", int'(edge_pulse), 0);
    @(negedge clock);                    // c=35 redraw one pixel right
    check("c35_x", int'(x), 11);
    check("c35_colour", int'(colour), 2);

    // ready alternating through a whole draw
    wait_update(got);
    check("toggle_found_update", int'(got), 1);
    r = 1'b1; ready = r; n = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      r = ~r; ready = r;
      if (done) begin got = 1'b1; break; end
      if (plot && colour == COL) n++;
    end
    ready = 1'b1;
    check("toggle_done_seen", int'(got), 1);
    check("toggle_draw_cycles", n, 32);

    // enable low: sprite must settle and stay idle
    enable = 1'b0;
    repeat (120) @(negedge clock);
    n = 0;
    repeat (100) begin
      @(negedge clock);
      if (plot || busy) n++;
    end
    check("frozen_idle_cycles", n, 0);
    enable = 1'b1;

    // borders: left, right, down, up
    dir = 2'b01;
    run_until_edge(3000, got, gx, gy);
    check("left_edge_seen", int'(got), 1);
    check("left_edge_x", gx, WRAP ? MAXX : 0);
    dir = 2'b00;
    run_until_edge(8000, got, gx, gy);
    check("right_edge_seen", int'(got), 1);
    check("right_edge_x", gx, WRAP ? 0 : MAXX);
    dir = 2'b10;
    run_until_edge(5000, got, gx, gy);
    check("down_edge_seen", int'(got), 1);
    check("down_edge_y", gy, WRAP ? 0 : MAXY);
    dir = 2'b11;
    run_until_edge(6000, got, gx, gy);
    check("up_edge_seen", int'(got), 1);
    check("up_edge_y", gy, WRAP ? MAXY : 0);

    // reset pulse at draw pixel 7
    wait_update(got);
    check("rst_found_update", int'(got), 1);
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_plot", int'(plot), 0);
    check("midrst_x", int'(x), 10);
    check("midrst_y", int'(y), 58);
    resetn = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; break; end
      if (plot && colour == COL) n++;
    end
    check("redraw_done_seen", int'(got), 1);
    check("redraw_pixels", n, 16);

    repeat (40) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
